// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcode/funct fields, ALU op and
// result-select codes, and the ID/EX load-select enum.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_MOVZ = 6'b001010;
  localparam logic [5:0] F_MOVN = 6'b001011;
  localparam logic [5:0] F_SYNC = 6'b001111;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;

  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_SRL  = 8'h02;
  localparam logic [7:0] ALUOP_SRA  = 8'h03;
  localparam logic [7:0] ALUOP_MOVZ = 8'h0A;
  localparam logic [7:0] ALUOP_MOVN = 8'h0B;
  localparam logic [7:0] ALUOP_MFHI = 8'h10;
  localparam logic [7:0] ALUOP_MTHI = 8'h11;
  localparam logic [7:0] ALUOP_MFLO = 8'h12;
  localparam logic [7:0] ALUOP_MTLO = 8'h13;
  localparam logic [7:0] ALUOP_AND  = 8'h24;
  localparam logic [7:0] ALUOP_OR   = 8'h25;
  localparam logic [7:0] ALUOP_XOR  = 8'h26;
  localparam logic [7:0] ALUOP_NOR  = 8'h27;
  localparam logic [7:0] ALUOP_SLL  = 8'h7C;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT} dst_e;
  typedef enum logic [1:0] {IMM_NONE, IMM_ZEXT, IMM_LUI, IMM_SHAMT} imm_e;
  typedef enum logic [1:0] {LD_HOLD, LD_BUBBLE, LD_DEC} ld_e;

  // Immediate and variable shifts share the low two funct bits.
  function automatic logic [7:0] shift_aluop(input logic [1:0] f);
    case (f)
      2'b00:   shift_aluop = ALUOP_SLL;
      2'b10:   shift_aluop = ALUOP_SRL;
      2'b11:   shift_aluop = ALUOP_SRA;
      default: shift_aluop = ALUOP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS instruction decode: op codes, read enables, immediate,
// destination register and the reserved-instruction flag.
module id_decode
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst,
  output logic [7:0]        aluop,
  output logic [2:0]        alusel,
  output logic              reg1_read,
  output logic              reg2_read,
  output logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] wd,
  output logic              wreg_raw,
  output logic              inst_invalid
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;
  dst_e       dst;
  imm_e       imm_k;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sa    = inst[10:6];
  assign funct = inst[5:0];

  always_comb begin
    aluop        = ALUOP_NOP;
    alusel       = SEL_NOP;
    reg1_read    = 1'b0;
    reg2_read    = 1'b0;
    dst          = DST_NONE;
    imm_k        = IMM_NONE;
    wreg_raw     = 1'b0;
    inst_invalid = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_AND, F_OR, F_XOR, F_NOR: begin
            aluop     = {2'b00, funct};
            alusel    = SEL_LOGIC;
            reg1_read = 1'b1;
            reg2_read = 1'b1;
            dst       = DST_RD;
            wreg_raw  = 1'b1;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            aluop     = shift_aluop(funct[1:0]);
            alusel    = SEL_SHIFT;
            reg1_read = 1'b1;
            reg2_read = 1'b1;
            dst       = DST_RD;
            wreg_raw  = 1'b1;
          end
          F_SLL, F_SRL, F_SRA: begin
            // rs must be zero; the shamt rides in operand 1 as an immediate
            if (rs == 5'd0) begin
              aluop     = shift_aluop(funct[1:0]);
              alusel    = SEL_SHIFT;
              reg2_read = 1'b1;
              imm_k     = IMM_SHAMT;
              dst       = DST_RD;
              wreg_raw  = 1'b1;
            end else begin
              inst_invalid = 1'b1;
            end
          end
          F_MFHI, F_MFLO: begin
            aluop    = {2'b00, funct};
            alusel   = SEL_MOVE;
            dst      = DST_RD;
            wreg_raw = 1'b1;
          end
          F_MTHI, F_MTLO: begin
            aluop     = {2'b00, funct};
            alusel    = SEL_MOVE;
            reg1_read = 1'b1;
          end
          F_MOVN, F_MOVZ: begin
            aluop     = {2'b00, funct};
            alusel    = SEL_MOVE;
            reg1_read = 1'b1;
            reg2_read = 1'b1;
            dst       = DST_RD;
            wreg_raw  = 1'b1;
          end
          F_SYNC: ;
          default: inst_invalid = 1'b1;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        aluop     = (op == OP_ORI) ? ALUOP_OR : (op == OP_ANDI) ? ALUOP_AND : ALUOP_XOR;
        alusel    = SEL_LOGIC;
        reg1_read = 1'b1;
        imm_k     = IMM_ZEXT;
        dst       = DST_RT;
        wreg_raw  = 1'b1;
      end
      OP_LUI: begin
        // Both operands take the shifted immediate so OR yields it unchanged
        aluop    = ALUOP_OR;
        alusel   = SEL_LOGIC;
        imm_k    = IMM_LUI;
        dst      = DST_RT;
        wreg_raw = 1'b1;
      end
      OP_PREF: ;
      default: inst_invalid = 1'b1;
    endcase
  end

  always_comb begin
    case (imm_k)
      IMM_ZEXT:  imm = DATA_W'(inst[15:0]);
      IMM_LUI:   imm = DATA_W'({inst[15:0], 16'h0000});
      IMM_SHAMT: imm = DATA_W'(sa);
      default:   imm = '0;
    endcase
    case (dst)
      DST_RD:  wd = REG_AW'(rd);
      DST_RT:  wd = REG_AW'(rt);
      default: wd = REG_AW'(NOP_REG_ADDR);
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with N-source forwarding, $0 protection, MOVN/MOVZ write
// resolution, load-use hazard bubbles and a registered ID/EX stage.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid_i,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      ex_is_load_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      stallreq_o,
  output logic                      ex_valid_o,
  output logic [DATA_W-1:0]         ex_pc_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [REG_AW-1:0]         ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_inst_invalid_o,
  output logic [CNT_W-1:0]          bubble_cnt_o
);

  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_wd;
  logic [NUM_FWD-1:0][DATA_W-1:0] fwd_wdata;

  assign fwd_wd    = fwd_wd_i;
  assign fwd_wdata = fwd_wdata_i;

  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic [DATA_W-1:0] imm;
  logic [REG_AW-1:0] wd;
  logic              wreg_raw, inst_invalid;

  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
    .inst         (inst_i),
    .aluop        (aluop),
    .alusel       (alusel),
    .reg1_read    (reg1_read_o),
    .reg2_read    (reg2_read_o),
    .imm          (imm),
    .wd           (wd),
    .wreg_raw     (wreg_raw),
    .inst_invalid (inst_invalid)
  );

  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  // Scan oldest to youngest so the lowest matching index wins.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic                           rd_en,
    input logic [REG_AW-1:0]              addr,
    input logic [DATA_W-1:0]              rf_data,
    input logic [DATA_W-1:0]              imm_v,
    input logic [NUM_FWD-1:0]             we,
    input logic [NUM_FWD-1:0][REG_AW-1:0] wdst,
    input logic [NUM_FWD-1:0][DATA_W-1:0] wdat
  );
    fwd_pick = rf_data;
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (we[k] && wdst[k] == addr) fwd_pick = wdat[k];
    if (addr == '0) fwd_pick = '0;
    if (!rd_en) fwd_pick = imm_v;
  endfunction

  logic [DATA_W-1:0] op1, op2;
  logic              wreg;

  assign op1 = fwd_pick(reg1_read_o, reg1_addr_o, reg1_data_i, imm, fwd_we_i, fwd_wd, fwd_wdata);
  assign op2 = fwd_pick(reg2_read_o, reg2_addr_o, reg2_data_i, imm, fwd_we_i, fwd_wd, fwd_wdata);

  always_comb begin
    wreg = wreg_raw && (wd != '0);
    if (aluop == ALUOP_MOVN) wreg = wreg && (op2 != '0);
    if (aluop == ALUOP_MOVZ) wreg = wreg && (op2 == '0);
  end

  assign stallreq_o = inst_valid_i && ex_is_load_i && fwd_we_i[0] && (fwd_wd[0] != '0) &&
                      ((reg1_read_o && reg1_addr_o == fwd_wd[0]) ||
                       (reg2_read_o && reg2_addr_o == fwd_wd[0]));

  ld_e ld;

  always_comb begin
    ld = LD_BUBBLE;
    if (flush_i)           ld = LD_BUBBLE;
    else if (stall_i)      ld = LD_HOLD;
    else if (stallreq_o)   ld = LD_BUBBLE;
    else if (inst_valid_i) ld = LD_DEC;
  end

  always_ff @(posedge clk) begin
    if (!rst || ld == LD_BUBBLE) begin
      ex_valid_o        <= 1'b0;
      ex_pc_o           <= '0;
      ex_aluop_o        <= ALUOP_NOP;
      ex_alusel_o       <= SEL_NOP;
      ex_reg1_o         <= '0;
      ex_reg2_o         <= '0;
      ex_wd_o           <= '0;
      ex_wreg_o         <= 1'b0;
      ex_inst_invalid_o <= 1'b0;
    end else if (ld == LD_DEC) begin
      ex_valid_o        <= 1'b1;
      ex_pc_o           <= pc_i;
      ex_aluop_o        <= aluop;
      ex_alusel_o       <= alusel;
      ex_reg1_o         <= op1;
      ex_reg2_o         <= op2;
      ex_wd_o           <= wd;
      ex_wreg_o         <= wreg;
      ex_inst_invalid_o <= inst_invalid;
    end
  end

  // Only bubbles caused by our own hazard count; flush/stall take precedence.
  always_ff @(posedge clk) begin
    if (!rst)
      bubble_cnt_o <= '0;
    else if (!flush_i && !stall_i && stallreq_o && bubble_cnt_o != {CNT_W{1'b1}})
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed scenarios followed by random
// traffic, each cycle's expected ID/EX state predicted from instruction mnemonics.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc, inst;
  logic        reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_wd;
  logic [63:0] fwd_wdata;
  logic        ex_is_load, stall, flush, stallreq;
  logic        ex_valid, ex_wreg, ex_inst_invalid;
  logic [31:0] ex_pc, ex_reg1, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [4:0]  ex_wd;
  logic [15:0] bubble_cnt;

  logic [31:0] rf [32];
  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
    .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .fwd_we_i(fwd_we), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
    .ex_is_load_i(ex_is_load), .stall_i(stall), .flush_i(flush),
    .stallreq_o(stallreq), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel), .ex_reg1_o(ex_reg1),
    .ex_reg2_o(ex_reg2), .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg),
    .ex_inst_invalid_o(ex_inst_invalid), .bubble_cnt_o(bubble_cnt)
  );

  typedef enum int {
    M_OR, M_AND, M_XOR, M_NOR, M_SLLV, M_SRLV, M_SRAV, M_SLL, M_SRL, M_SRA,
    M_MFHI, M_MFLO, M_MTHI, M_MTLO, M_MOVN, M_MOVZ, M_ORI, M_ANDI, M_XORI,
    M_LUI, M_SYNC, M_PREF, M_INV, M_INV_R, M_COUNT
  } mn_e;

  typedef struct {
    bit          rst_n, iv, load, stall, flush;
    mn_e         mn;
    bit [4:0]    rs, rt, rd, sa;
    bit [15:0]   imm;
    bit [31:0]   pc;
    bit [1:0]    we;
    bit [4:0]    wd0, wd1;
    bit [31:0]   d0, d1;
  } stim_t;

  typedef struct packed {
    bit        valid;
    bit [31:0] pc;
    bit [7:0]  aluop;
    bit [2:0]  sel;
    bit [31:0] r1, r2;
    bit [4:0]  wd;
    bit        wreg, inv;
    bit [15:0] cnt;
  } st_t;

  typedef struct packed { bit stallreq, rd1, rd2; } comb_t;

  st_t   cur;
  st_t   rq[$];
  comb_t cq[$];
  int    checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Mnemonic -> architectural meaning: op code, select, sources, destination, immediate.
  task automatic props(input stim_t s, output bit [7:0] aop, output bit [2:0] sel,
                       output bit urs, output bit urt, output int dst,
                       output bit [31:0] immv, output bit inv);
    aop = 8'h00; sel = 3'd0; urs = 0; urt = 0; dst = 0; immv = 0; inv = 0;
    case (s.mn)
      M_OR:   begin aop = 8'h25; sel = 1; urs = 1; urt = 1; dst = 1; end
      M_AND:  begin aop = 8'h24; sel = 1; urs = 1; urt = 1; dst = 1; end
      M_XOR:  begin aop = 8'h26; sel = 1; urs = 1; urt = 1; dst = 1; end
      M_NOR:  begin aop = 8'h27; sel = 1; urs = 1; urt = 1; dst = 1; end
      M_SLLV: begin aop = 8'h7C; sel = 2; urs = 1; urt = 1; dst = 1; end
      M_SRLV: begin aop = 8'h02; sel = 2; urs = 1; urt = 1; dst = 1; end
      M_SRAV: begin aop = 8'h03; sel = 2; urs = 1; urt = 1; dst = 1; end
      M_SLL:  begin aop = 8'h7C; sel = 2; urt = 1; dst = 1; immv = 32'(s.sa); end
      M_SRL:  begin aop = 8'h02; sel = 2; urt = 1; dst = 1; immv = 32'(s.sa); end
      M_SRA:  begin aop = 8'h03; sel = 2; urt = 1; dst = 1; immv = 32'(s.sa); end
      M_MFHI: begin aop = 8'h10; sel = 3; dst = 1; end
      M_MFLO: begin aop = 8'h12; sel = 3; dst = 1; end
      M_MTHI: begin aop = 8'h11; sel = 3; urs = 1; end
      M_MTLO: begin aop = 8'h13; sel = 3; urs = 1; end
      M_MOVN: begin aop = 8'h0B; sel = 3; urs = 1; urt = 1; dst = 1; end
      M_MOVZ: begin aop = 8'h0A; sel = 3; urs = 1; urt = 1; dst = 1; end
      M_ORI:  begin aop = 8'h25; sel = 1; urs = 1; dst = 2; immv = {16'h0, s.imm}; end
      M_ANDI: begin aop = 8'h24; sel = 1; urs = 1; dst = 2; immv = {16'h0, s.imm}; end
      M_XORI: begin aop = 8'h26; sel = 1; urs = 1; dst = 2; immv = {16'h0, s.imm}; end
      M_LUI:  begin aop = 8'h25; sel = 1; dst = 2; immv = {s.imm, 16'h0}; end
      M_INV, M_INV_R: inv = 1;
      default: ;
    endcase
  endtask

  function automatic bit [31:0] encode(input stim_t s);
    bit [5:0] f;
    f = 6'h00;
    case (s.mn)
      M_OR: f = 6'h25;  M_AND: f = 6'h24;  M_XOR: f = 6'h26;  M_NOR: f = 6'h27;
      M_SLLV: f = 6'h04; M_SRLV: f = 6'h06; M_SRAV: f = 6'h07;
      M_SLL: f = 6'h00; M_SRL: f = 6'h02;  M_SRA: f = 6'h03;
      M_MFHI: f = 6'h10; M_MTHI: f = 6'h11; M_MFLO: f = 6'h12; M_MTLO: f = 6'h13;
      M_MOVZ: f = 6'h0A; M_MOVN: f = 6'h0B; M_SYNC: f = 6'h0F; M_INV_R: f = 6'h2A;
      default: ;
    endcase
    case (s.mn)
      M_SLL, M_SRL, M_SRA: encode = {6'b0, 5'b0, s.rt, s.rd, s.sa, f};
      M_MFHI, M_MFLO:      encode = {6'b0, 10'b0, s.rd, 5'b0, f};
      M_MTHI, M_MTLO:      encode = {6'b0, s.rs, 15'b0, f};
      M_SYNC:              encode = {26'b0, f};
      M_ORI:  encode = {6'b001101, s.rs, s.rt, s.imm};
      M_ANDI: encode = {6'b001100, s.rs, s.rt, s.imm};
      M_XORI: encode = {6'b001110, s.rs, s.rt, s.imm};
      M_LUI:  encode = {6'b001111, s.rs, s.rt, s.imm};
      M_PREF: encode = {6'b110011, s.rs, s.rt, s.imm};
      M_INV:  encode = {6'b111111, s.rs, s.rt, s.imm};
      default: encode = {6'b0, s.rs, s.rt, s.rd, 5'b0, f};
    endcase
  endfunction

  function automatic bit [31:0] operand(input stim_t s, input bit used, input bit [4:0] a,
                                        input bit [31:0] immv);
    if (!used) return immv;
    if (a == 0) return 0;
    if (s.we[0] && s.wd0 == a) return s.d0;
    if (s.we[1] && s.wd1 == a) return s.d1;
    return rf[a];
  endfunction

  task automatic step(input stim_t s);
    bit [7:0] aop; bit [2:0] sel; bit urs, urt, inv, haz, wr; int dst;
    bit [31:0] immv, o1, o2; bit [4:0] wdx; st_t bub;
    @(negedge clk);
    rst = s.rst_n; inst_valid = s.iv; pc = s.pc; inst = encode(s);
    fwd_we = s.we; fwd_wd = {s.wd1, s.wd0}; fwd_wdata = {s.d1, s.d0};
    ex_is_load = s.load; stall = s.stall; flush = s.flush;
    props(s, aop, sel, urs, urt, dst, immv, inv);
    o1  = operand(s, urs, s.rs, immv);
    o2  = operand(s, urt, s.rt, immv);
    wdx = (dst == 1) ? s.rd : (dst == 2) ? s.rt : 5'd0;
    wr  = (dst != 0) && (wdx != 0);
    if (s.mn == M_MOVN) wr = wr && (o2 != 0);
    if (s.mn == M_MOVZ) wr = wr && (o2 == 0);
    haz = s.iv && s.load && s.we[0] && s.wd0 != 0 &&
          ((urs && s.rs == s.wd0) || (urt && s.rt == s.wd0));
    cq.push_back('{haz, urs, urt});
    bub = '0;
    bub.cnt = cur.cnt;
    if (!s.rst_n) cur = '0;
    else if (s.flush) cur = bub;
    else if (s.stall) ;
    else if (haz) begin
      cur = bub;
      if (cur.cnt != 16'hFFFF) cur.cnt = cur.cnt + 1;
    end else if (s.iv) cur = '{1'b1, s.pc, aop, sel, o1, o2, wdx, wr, inv, cur.cnt};
    else cur = bub;
    rq.push_back(cur);
  endtask

  // Monitors: combinational outputs mid-low-phase, registered outputs after each edge.
  initial forever begin
    comb_t e;
    @(negedge clk); #2;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("stallreq", 32'(stallreq), 32'(e.stallreq));
      chk("reg1_read", 32'(reg1_read), 32'(e.rd1));
      chk("reg2_read", 32'(reg2_read), 32'(e.rd2));
    end
  end

  initial forever begin
    st_t e;
    @(posedge clk); #1;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_aluop", 32'(ex_aluop), 32'(e.aluop));
      chk("ex_alusel", 32'(ex_alusel), 32'(e.sel));
      chk("ex_reg1", ex_reg1, e.r1);
      chk("ex_reg2", ex_reg2, e.r2);
      chk("ex_wd", 32'(ex_wd), 32'(e.wd));
      chk("ex_wreg", 32'(ex_wreg), 32'(e.wreg));
      chk("ex_inst_invalid", 32'(ex_inst_invalid), 32'(e.inv));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
    end
  end

  function automatic stim_t base(input mn_e mn);
    stim_t s;
    s = '{rst_n: 1, iv: 1, load: 0, stall: 0, flush: 0, mn: mn, rs: 0, rt: 0, rd: 0,
          sa: 0, imm: 0, pc: 32'h0040_0000, we: 0, wd0: 0, wd1: 0, d0: 0, d1: 0};
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 0; inst_valid = 0; pc = 0; inst = 0; fwd_we = 0; fwd_wd = 0; fwd_wdata = 0;
    ex_is_load = 0; stall = 0; flush = 0;
    cur = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;

    s = base(M_OR); s.rst_n = 0; step(s); step(s);

    s = base(M_ORI); s.rt = 1; s.imm = 16'h1100; step(s);

    s = base(M_OR); s.rd = 4; s.rs = 3; s.rt = 3; s.pc = 32'h100;
    s.we = 2'b11; s.wd0 = 3; s.wd1 = 3; s.d0 = 32'hAAAA; s.d1 = 32'hBBBB; step(s);
    s.we = 2'b10; step(s);

    s = base(M_AND); s.rd = 5; s.rs = 2; s.rt = 6; s.pc = 32'h104;
    s.load = 1; s.we = 2'b01; s.wd0 = 2; s.d0 = 32'h1234_5678; step(s);
    s.stall = 1; step(s); step(s); step(s);
    s.flush = 1; step(s);
    s.stall = 0; s.flush = 0; step(s);
    s.load = 0; step(s);
    s.load = 1; s.we = 2'b00; step(s);

    s = base(M_MOVZ); s.rd = 7; s.rs = 8; s.rt = 9; s.we = 2'b01; s.wd0 = 9; s.d0 = 0; step(s);
    s.mn = M_MOVN; step(s);
    s.d0 = 32'h5; step(s);

    s = base(M_INV); step(s);
    s = base(M_SLL); step(s);
    s = base(M_LUI); s.rt = 3; s.imm = 16'hBEEF; step(s);
    s.iv = 0; step(s);
    s = base(M_OR); s.rst_n = 0; step(s);

    for (int n = 0; n < 600; n++) begin
      s = base(mn_e'($urandom_range(0, int'(M_COUNT) - 1)));
      s.rst_n = ($urandom_range(0, 59) != 0);
      s.iv    = ($urandom_range(0, 7) != 0);
      s.load  = ($urandom_range(0, 2) == 0);
      s.stall = ($urandom_range(0, 7) == 0);
      s.flush = ($urandom_range(0, 15) == 0);
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7)); s.sa = 5'($urandom);
      s.imm = 16'($urandom); s.pc = $urandom;
      s.we = 2'($urandom); s.wd0 = 5'($urandom_range(0, 7)); s.wd1 = 5'($urandom_range(0, 7));
      s.d0 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom; s.d1 = $urandom;
      step(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (rq.size() != 0 || cq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", rq.size() + cq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
